// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/host arbiter for the shared byte-memory port
module mem_port_arbiter #(
    parameter int AWIDTH       = 8,
    parameter int DWIDTH       = 8,
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AWIDTH-1:0] cpu_adr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic [DWIDTH-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [AWIDTH-1:0] host_adr,
    input  logic [DWIDTH-1:0] host_wdata,
    output logic [DWIDTH-1:0] host_rdata,
    output logic              host_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_adr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [1:0]        state;
    logic              win_host;
    logic              lat_we;
    logic [AWIDTH-1:0] lat_adr;
    logic [DWIDTH-1:0] lat_wdata;
    logic [3:0]        wcnt;
    logic [3:0]        scnt;
    logic              host_wins;

    // Host has priority, except that the CPU wins once it has been passed over STARVE_LIMIT times.
    assign host_wins = host_req & (~cpu_req | (scnt != STARVE_MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            win_host   <= 1'b0;
            lat_we     <= 1'b0;
            lat_adr    <= '0;
            lat_wdata  <= '0;
            wcnt       <= '0;
            scnt       <= '0;
            cpu_rdata  <= '0;
            host_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (host_req || cpu_req) begin
                        win_host  <= host_wins;
                        lat_we    <= host_wins ? host_we    : cpu_we;
                        lat_adr   <= host_wins ? host_adr   : cpu_adr;
                        lat_wdata <= host_wins ? host_wdata : cpu_wdata;
                        wcnt      <= WAIT_INIT;
                        state     <= ACCESS;
                        if (!host_wins) begin
                            scnt <= '0;
                        end else if (cpu_req && scnt != STARVE_MAX) begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                end
                ACCESS: begin
                    if (wcnt != 4'd0) begin
                        wcnt <= wcnt - 4'd1;
                    end else begin
                        if (!lat_we) begin
                            if (win_host) begin
                                host_rdata <= mem_rdata;
                            end else begin
                                cpu_rdata <= mem_rdata;
                            end
                        end
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_en     = (state == ACCESS);
    assign mem_we     = mem_en & lat_we;
    assign mem_adr    = lat_adr;
    assign mem_wdata  = lat_wdata;
    assign cpu_ready  = (state == RESP) & ~win_host;
    assign host_ready = (state == RESP) & win_host;
    assign cpu_stall  = cpu_req & ~cpu_ready;

endmodule
